// File: rtl/pcpu_mem_loader.sv
// Dual 256x16 memories for a tiny CPU plus a host-side burst loader.
// CPU reads are combinational; loader writes only while the CPU is halted.
module pcpu_mem_loader (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_run,
  input  logic [7:0]  i_addr,
  output logic [15:0] i_datain,
  input  logic [7:0]  d_addr,
  input  logic        d_we,
  input  logic [15:0] d_dataout,
  output logic [15:0] d_datain,
  input  logic        ld_start,
  input  logic        ld_sel,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_busy,
  output logic        ld_done,
  output logic        ld_err,
  output logic [8:0]  ld_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        sel_q, sel_d;
  logic        beat, top_addr, start_ok;

  logic [15:0] imem_q [256];
  logic [15:0] dmem_q [256];

  assign beat     = ld_valid & ld_ready;
  assign top_addr = (addr_q == 8'hFF);
  assign start_ok = ld_start & ~cpu_run;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_ok) state_d = S_LOAD;
      S_LOAD: begin
        if (cpu_run)
          state_d = S_DONE;
        else if (beat && (ld_last || top_addr))
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // CPU stores to dmem take priority over a dmem burst.
  always_comb begin
    ld_ready = 1'b0;
    ld_busy  = 1'b0;
    ld_done  = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        ld_busy  = 1'b1;
        ld_ready = ~cpu_run & ~(sel_q & d_we);
      end
      S_DONE:  ld_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    sel_d  = sel_q;
    if (state_q == S_IDLE && start_ok) begin
      sel_d  = ld_sel;
      addr_d = 8'd0;
      cnt_d  = 9'd0;
      err_d  = 1'b0;
    end else if (state_q == S_LOAD) begin
      if (cpu_run) begin
        err_d = 1'b1;
      end else if (beat) begin
        cnt_d = cnt_q + 9'd1;
        if (!top_addr) addr_d = addr_q + 8'd1;
        if (top_addr && !ld_last) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= 8'd0;
      cnt_q  <= 9'd0;
      err_q  <= 1'b0;
      sel_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      sel_q  <= sel_d;
    end
  end

  // Storage is never cleared; reset only blocks the loader's write.
  always_ff @(posedge clock) begin
    if (beat && !sel_q && !reset)
      imem_q[addr_q] <= ld_data;
    if (d_we)
      dmem_q[d_addr] <= d_dataout;
    else if (beat && sel_q && !reset)
      dmem_q[addr_q] <= ld_data;
  end

  assign i_datain = imem_q[i_addr];
  assign d_datain = dmem_q[d_addr];
  assign ld_err   = err_q;
  assign ld_count = cnt_q;

endmodule

// File: tb/tb_pcpu_mem_loader.sv
// Directed bench for pcpu_mem_loader.
// Inputs change 1ns after the rising edge; outputs are checked there.
module tb_pcpu_mem_loader;

  logic        clock = 0;
  logic        reset, cpu_run;
  logic [7:0]  i_addr, d_addr;
  logic [15:0] i_datain, d_datain, d_dataout, ld_data;
  logic        d_we, ld_start, ld_sel, ld_valid, ld_last;
  logic        ld_ready, ld_busy, ld_done, ld_err;
  logic [8:0]  ld_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pcpu_mem_loader dut (
    .clock(clock), .reset(reset), .cpu_run(cpu_run),
    .i_addr(i_addr), .i_datain(i_datain),
    .d_addr(d_addr), .d_we(d_we),
    .d_dataout(d_dataout), .d_datain(d_datain),
    .ld_start(ld_start), .ld_sel(ld_sel),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready),
    .ld_busy(ld_busy), .ld_done(ld_done),
    .ld_err(ld_err), .ld_count(ld_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_burst(input logic sel);
    ld_start = 1; ld_sel = sel;
    tick();
    ld_start = 0; ld_sel = 0;
  endtask

  task automatic test_reset();
    reset = 1; cpu_run = 0; i_addr = 0; d_addr = 0;
    d_we = 0; d_dataout = 0; ld_start = 0; ld_sel = 0;
    ld_valid = 0; ld_data = 0; ld_last = 0;
    tick(); tick();
    reset = 0; #1;
    total++;
    if ({ld_busy, ld_done, ld_err, ld_ready} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=0000",
               {ld_busy, ld_done, ld_err, ld_ready});
    end
    total++;
    if (ld_count !== 9'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d exp=0", ld_count);
    end
  endtask

  task automatic test_load_imem();
    logic [15:0] w;
    start_burst(1'b0);
    total++;
    if (ld_busy !== 1 || ld_ready !== 1) begin
      bad++;
      $display("FAIL load_busy got=%b%b exp=11", ld_busy, ld_ready);
    end
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_last = (i == 3);
      ld_data  = 16'h1111 * 16'(i + 1);
      tick();
    end
    ld_valid = 0; ld_last = 0;
    total++;
    if (ld_done !== 1 || ld_err !== 0 || ld_busy !== 0) begin
      bad++;
      $display("FAIL load_done got=%b%b%b exp=100",
               ld_done, ld_err, ld_busy);
    end
    total++;
    if (ld_count !== 9'd4) begin
      bad++;
      $display("FAIL load_count got=%0d exp=4", ld_count);
    end
    tick();
    total++;
    if (ld_done !== 0) begin
      bad++;
      $display("FAIL load_pulse got=%b exp=0", ld_done);
    end
    for (int i = 0; i < 4; i++) begin
      i_addr = 8'(3 - i); #1;
      w = 16'h1111 * 16'(4 - i);
      total++;
      if (i_datain !== w) begin
        bad++;
        $display("FAIL load_imem%0d got=%h exp=%h", 3 - i, i_datain, w);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] w;
    start_burst(1'b1);
    for (int c = 0; c < 5; c++) begin
      ld_valid = (c % 2 == 0);
      ld_data  = (c % 2 == 0) ? 16'hA001 + 16'(c / 2) : 16'hFFFF;
      ld_last  = (c == 4);
      tick();
      total++;
      if (ld_count !== 9'(c / 2 + 1)) begin
        bad++;
        $display("FAIL bp_count%0d got=%0d exp=%0d",
                 c, ld_count, c / 2 + 1);
      end
    end
    ld_valid = 0; ld_last = 0;
    total++;
    if (ld_done !== 1) begin
      bad++;
      $display("FAIL bp_done got=%b exp=1", ld_done);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      d_addr = 8'(i); #1;
      w = 16'hA001 + 16'(i);
      total++;
      if (d_datain !== w) begin
        bad++;
        $display("FAIL bp_dmem%0d got=%h exp=%h", i, d_datain, w);
      end
    end
  endtask

  task automatic test_overflow();
    start_burst(1'b0);
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1; ld_data = 16'h0100 + 16'(i);
      tick();
    end
    ld_data = 16'h0200;
    #1;
    total++;
    if (ld_ready !== 0 || ld_done !== 1 || ld_err !== 1) begin
      bad++;
      $display("FAIL ovf_flags got=%b%b%b exp=011",
               ld_ready, ld_done, ld_err);
    end
    total++;
    if (ld_count !== 9'd256) begin
      bad++;
      $display("FAIL ovf_count got=%0d exp=256", ld_count);
    end
    tick();
    ld_valid = 0;
    total++;
    if (ld_count !== 9'd256 || ld_err !== 1) begin
      bad++;
      $display("FAIL ovf_hold got=%0d/%b exp=256/1", ld_count, ld_err);
    end
    i_addr = 8'd0; #1;
    total++;
    if (i_datain !== 16'h0100) begin
      bad++;
      $display("FAIL ovf_imem0 got=%h exp=0100", i_datain);
    end
    i_addr = 8'd255; #1;
    total++;
    if (i_datain !== 16'h01FF) begin
      bad++;
      $display("FAIL ovf_imem255 got=%h exp=01ff", i_datain);
    end
  endtask

  task automatic test_abort();
    start_burst(1'b1);
    total++;
    if (ld_err !== 0 || ld_count !== 9'd0) begin
      bad++;
      $display("FAIL abort_clr got=%b/%0d exp=0/0", ld_err, ld_count);
    end
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1; ld_data = 16'h5A01 + 16'(i);
      tick();
    end
    cpu_run = 1; ld_data = 16'hDEAD;
    tick();
    ld_valid = 0;
    total++;
    if (ld_done !== 1 || ld_err !== 1 || ld_count !== 9'd2) begin
      bad++;
      $display("FAIL abort_done got=%b%b/%0d exp=11/2",
               ld_done, ld_err, ld_count);
    end
    tick();
    ld_start = 1; ld_sel = 1;
    tick();
    ld_start = 0; ld_sel = 0;
    total++;
    if (ld_busy !== 0 || ld_err !== 1 || ld_done !== 0) begin
      bad++;
      $display("FAIL abort_ign got=%b%b%b exp=010",
               ld_busy, ld_err, ld_done);
    end
    cpu_run = 0;
    d_addr = 8'd1; #1;
    total++;
    if (d_datain !== 16'h5A02) begin
      bad++;
      $display("FAIL abort_dmem1 got=%h exp=5a02", d_datain);
    end
    d_addr = 8'd2; #1;
    total++;
    if (d_datain !== 16'hA003) begin
      bad++;
      $display("FAIL abort_dmem2 got=%h exp=a003", d_datain);
    end
  endtask

  task automatic test_collision();
    d_we = 1; d_addr = 8'h05; d_dataout = 16'h1234;
    tick();
    d_we = 0;
    start_burst(1'b1);
    d_we = 1; d_dataout = 16'hBEEF;
    ld_valid = 1; ld_data = 16'h7777; #1;
    total++;
    if (ld_ready !== 0) begin
      bad++;
      $display("FAIL col_ready got=%b exp=0", ld_ready);
    end
    total++;
    if (d_datain !== 16'h1234) begin
      bad++;
      $display("FAIL col_old got=%h exp=1234", d_datain);
    end
    tick();
    d_we = 0; ld_valid = 0; #1;
    total++;
    if (d_datain !== 16'hBEEF || ld_count !== 9'd0) begin
      bad++;
      $display("FAIL col_new got=%h/%0d exp=beef/0", d_datain, ld_count);
    end
    ld_valid = 1; ld_last = 1;
    tick();
    ld_valid = 0; ld_last = 0;
    d_addr = 8'd0; #1;
    total++;
    if (d_datain !== 16'h7777 || ld_done !== 1) begin
      bad++;
      $display("FAIL col_end got=%h/%b exp=7777/1", d_datain, ld_done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start_burst(1'b1);
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1; ld_data = 16'hC001 + 16'(i);
      tick();
    end
    ld_data = 16'hC003; reset = 1;
    tick();
    reset = 0; ld_valid = 0;
    total++;
    if (ld_count !== 9'd0 || ld_busy !== 0 || ld_done !== 0) begin
      bad++;
      $display("FAIL rst_mid got=%0d/%b%b exp=0/00",
               ld_count, ld_busy, ld_done);
    end
    tick();
    total++;
    if (ld_done !== 0 || ld_ready !== 0) begin
      bad++;
      $display("FAIL rst_nodone got=%b%b exp=00", ld_done, ld_ready);
    end
    for (int i = 0; i < 3; i++) begin
      logic [15:0] w;
      d_addr = 8'(i); #1;
      w = (i == 2) ? 16'hA003 : 16'hC001 + 16'(i);
      total++;
      if (d_datain !== w) begin
        bad++;
        $display("FAIL rst_dmem%0d got=%h exp=%h", i, d_datain, w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_imem();
    test_backpressure();
    test_overflow();
    test_abort();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
